// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard sequencing controller.
package ps2_kbd_pkg;

  // Pop sequencer states: capture, pop/decode, settle
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_POP    = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  localparam logic [7:0] BRK_CODE_DEF = 8'hF0;
  localparam logic [7:0] EXT_CODE_DEF = 8'hE0;

  // Width of one BCD digit; the press counter holds two of them
  localparam int BCD_W = 4;

endpackage

// File: rtl/bcd_cnt2.sv
// Two-digit BCD counter, 00..99 with wrap back to 00.
module bcd_cnt2
  import ps2_kbd_pkg::*;
(
  input  logic               clk,
  input  logic               clrn,
  input  logic               inc,
  output logic [2*BCD_W-1:0] cnt
);

  logic [1:0][BCD_W-1:0] dig;
  logic [1:0]            carry;

  // Ones digit steps on inc; tens digit steps when ones rolls over 9
  assign carry = {inc && (dig[0] == BCD_W'(9)), inc};

  // Per-digit increment with 9 -> 0 rollover
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      dig <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (carry[i]) dig[i] <= (dig[i] == BCD_W'(9)) ? '0 : dig[i] + BCD_W'(1);
      end
    end
  end

  assign cnt = dig;

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// Pops scancode bytes from the ps2_keyboard FIFO, decodes F0/E0 prefixes into
// make/break events, holds the current key, counts presses in BCD and latches
// FIFO overflow.
module ps2_kbd_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter logic [7:0]  BRK_CODE    = BRK_CODE_DEF,
  parameter logic [7:0]  EXT_CODE    = EXT_CODE_DEF,
  parameter logic [15:0] PFX_TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  input  logic       kb_overflow,
  output logic       nextdata_n,
  output logic [7:0] scancode,
  output logic       ext,
  output logic       key_down,
  output logic       evt_valid,
  output logic       evt_break,
  output logic [7:0] press_cnt,
  output logic       ovf_seen,
  input  logic       ovf_clr
);

  state_t      state;
  logic [7:0]  byte_r;
  logic        brk_pend;
  logic        ext_pend;
  logic [15:0] tmo_cnt;

  logic is_brk, is_ext, same_key, press_inc;

  assign is_brk   = (byte_r == BRK_CODE);
  assign is_ext   = (byte_r == EXT_CODE);
  assign same_key = (byte_r == scancode) && (ext_pend == ext);
  // A new press is a make that is not a typematic repeat of the held key
  assign press_inc = (state == S_POP) && !is_brk && !is_ext && !brk_pend &&
                     !(key_down && same_key);

  bcd_cnt2 u_press_cnt (
    .clk  (clk),
    .clrn (clrn),
    .inc  (press_inc),
    .cnt  (press_cnt)
  );

  // Pop sequencer, prefix decode, key state and prefix timeout
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= S_IDLE;
      nextdata_n <= 1'b1;
      byte_r     <= '0;
      scancode   <= '0;
      ext        <= 1'b0;
      key_down   <= 1'b0;
      evt_valid  <= 1'b0;
      evt_break  <= 1'b0;
      brk_pend   <= 1'b0;
      ext_pend   <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      evt_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (kb_ready) begin
            byte_r     <= kb_data;
            nextdata_n <= 1'b0;
            tmo_cnt    <= '0;
            state      <= S_POP;
          end else if ((brk_pend || ext_pend) && (PFX_TIMEOUT != 16'd0)) begin
            // Stale prefix: drop it after PFX_TIMEOUT idle cycles
            if (tmo_cnt == PFX_TIMEOUT - 16'd1) begin
              brk_pend <= 1'b0;
              ext_pend <= 1'b0;
              tmo_cnt  <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end
        end
        S_POP: begin
          nextdata_n <= 1'b1;
          state      <= S_SETTLE;
          if (is_brk) begin
            brk_pend <= 1'b1;
          end else if (is_ext) begin
            ext_pend <= 1'b1;
          end else if (brk_pend) begin
            evt_valid <= 1'b1;
            evt_break <= 1'b1;
            // Releasing some other key leaves the held key pressed
            if (same_key) key_down <= 1'b0;
            brk_pend <= 1'b0;
            ext_pend <= 1'b0;
          end else begin
            evt_valid <= 1'b1;
            evt_break <= 1'b0;
            if (!(key_down && same_key)) begin
              scancode <= byte_r;
              ext      <= ext_pend;
              key_down <= 1'b1;
            end
            ext_pend <= 1'b0;
          end
        end
        S_SETTLE: state <= S_IDLE;
        default: begin
          state      <= S_IDLE;
          nextdata_n <= 1'b1;
        end
      endcase
    end
  end

  // Sticky overflow flag; a new overflow beats a simultaneous clear
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)            ovf_seen <= 1'b0;
    else if (kb_overflow) ovf_seen <= 1'b1;
    else if (ovf_clr)     ovf_seen <= 1'b0;
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench for ps2_kbd_ctrl: a FIFO model feeds bytes, a key-state
// reference model predicts every make/break event, a monitor checks them.
module tb_ps2_kbd_ctrl;

  localparam logic [15:0] TMO = 16'd40;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] kb_data = '0;
  logic       kb_ready = 1'b0;
  logic       kb_overflow = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       nextdata_n;
  logic [7:0] scancode;
  logic       ext;
  logic       key_down;
  logic       evt_valid;
  logic       evt_break;
  logic [7:0] press_cnt;
  logic       ovf_seen;

  ps2_kbd_ctrl #(.PFX_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .kb_data     (kb_data),
    .kb_ready    (kb_ready),
    .kb_overflow (kb_overflow),
    .nextdata_n  (nextdata_n),
    .scancode    (scancode),
    .ext         (ext),
    .key_down    (key_down),
    .evt_valid   (evt_valid),
    .evt_break   (evt_break),
    .press_cnt   (press_cnt),
    .ovf_seen    (ovf_seen),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       brk;
    logic [7:0] sc;
    logic       ext;
    logic       down;
    logic [7:0] cnt;
  } exp_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  exp_t       exp_q[$];
  logic [7:0] fifo[$];
  logic       prev_low = 1'b0;
  int         nd_low_cnt = 0;

  // Reference key state
  logic [7:0] m_sc;
  logic       m_ext, m_down, m_brk, m_extp;
  int         m_presses;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_sc = '0; m_ext = 0; m_down = 0; m_brk = 0; m_extp = 0; m_presses = 0;
  endtask

  // Key-state rules applied to one byte in arrival order
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_extp = 1;
    else if (m_brk) begin
      if (b == m_sc && m_extp == m_ext) m_down = 0;
      m_brk = 0; m_extp = 0;
      exp_q.push_back('{1'b1, m_sc, m_ext, m_down, to_bcd(m_presses)});
    end else begin
      if (!(m_down && b == m_sc && m_extp == m_ext)) begin
        m_sc = b; m_ext = m_extp; m_down = 1;
        m_presses = (m_presses + 1) % 100;
      end
      m_extp = 0;
      exp_q.push_back('{1'b0, m_sc, m_ext, m_down, to_bcd(m_presses)});
    end
  endtask

  // One cycle: FIFO pops on the strobe, then the head is re-presented
  task automatic tick();
    @(negedge clk);
    if (!nextdata_n) begin
      nd_low_cnt++;
      chk("nd_consecutive_low", prev_low, 0);
      chk("pop_nonempty", fifo.size() > 0, 1);
      if (fifo.size() > 0) void'(fifo.pop_front());
    end
    prev_low = !nextdata_n;
    kb_ready = fifo.size() > 0;
    kb_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
  endtask

  task automatic send(input logic [7:0] b);
    fifo.push_back(b);
    model_byte(b);
    kb_ready = 1'b1;
    kb_data  = fifo[0];
  endtask

  task automatic drain();
    int budget = 0;
    while (fifo.size() > 0 && budget < 500) begin
      tick();
      budget++;
    end
    if (budget >= 500) chk("drain_timeout", 1, 0);
    repeat (4) tick();
  endtask

  task automatic idle_long();
    drain();
    repeat (2 * TMO + 10) tick();
    m_brk = 0; m_extp = 0;
  endtask

  // Monitor: every reported event must match the next predicted one
  always @(negedge clk) begin
    if (clrn && evt_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_evt", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("evt_break", evt_break, e.brk);
        chk("scancode", scancode, e.sc);
        chk("ext", ext, e.ext);
        chk("key_down", key_down, e.down);
        chk("press_cnt", press_cnt, e.cnt);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tbl [10];
    logic [7:0] k;
    int         w;
    tbl = '{8'h1C, 8'h32, 8'h75, 8'hF0, 8'hE0, 8'h1C, 8'h32, 8'hF0, 8'hE0, 8'h5A};
    model_reset();

    // Reset state
    repeat (3) tick();
    chk("rst_nextdata_n", nextdata_n, 1);
    chk("rst_scancode", scancode, 0);
    chk("rst_key_down", key_down, 0);
    chk("rst_press_cnt", press_cnt, 0);
    chk("rst_ovf_seen", ovf_seen, 0);
    chk("rst_evt_valid", evt_valid, 0);
    clrn = 1'b1;
    repeat (2) tick();

    // Single make: one-cycle pop strobe
    nd_low_cnt = 0;
    send(8'h1C);
    drain();
    chk("nd_low_cycles", nd_low_cnt, 1);
    chk("first_press_cnt", press_cnt, 8'h01);

    // Typematic repeats then release
    send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    drain();
    chk("repeat_press_cnt", press_cnt, 8'h01);
    chk("release_key_down", key_down, 0);

    // Extended key make and break
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    drain();
    chk("ext_scancode", scancode, 8'h75);
    chk("ext_flag", ext, 1);
    chk("ext_key_down", key_down, 0);

    // 100 distinct presses wrap the BCD counter
    for (int i = 0; i < 100; i++) begin
      k = (i % 2) ? 8'h32 : 8'h1C;
      send(k); send(8'hF0); send(k);
      drain();
    end
    chk("wrap_press_cnt", press_cnt, to_bcd(m_presses));

    // Short gap keeps the break prefix; long gap discards it
    send(8'h1C); drain();
    send(8'hF0); drain(); repeat (5) tick();
    send(8'h1C); drain();
    chk("short_gap_break", key_down, 0);
    send(8'hF0); idle_long();
    send(8'h1C); drain();
    chk("timeout_make", key_down, 1);

    // Randomized byte streams with bursts and occasional stale prefixes
    for (int i = 0; i < 300; i++) begin
      send(tbl[$urandom_range(0, 9)]);
      w = $urandom_range(0, 19);
      if (w == 0) idle_long();
      else if (w > 5) begin
        drain();
        repeat ($urandom_range(0, 6)) tick();
      end
    end
    drain();

    // Overflow latch and clear priority
    kb_overflow = 1'b1; tick(); kb_overflow = 1'b0; tick();
    chk("ovf_set", ovf_seen, 1);
    tick();
    chk("ovf_hold", ovf_seen, 1);
    kb_overflow = 1'b1; ovf_clr = 1'b1; tick(); kb_overflow = 1'b0; ovf_clr = 1'b0; tick();
    chk("ovf_set_wins", ovf_seen, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0; tick();
    chk("ovf_clr", ovf_seen, 0);

    // Reset dropped during the pop strobe
    send(8'h2B);
    kb_overflow = 1'b1; tick(); kb_overflow = 1'b0;
    begin
      int budget = 0;
      while (nextdata_n && budget < 20) begin
        tick();
        budget++;
      end
      chk("pop_seen_before_reset", nextdata_n, 0);
    end
    clrn = 1'b0;
    #1;
    chk("mid_rst_nextdata_n", nextdata_n, 1);
    chk("mid_rst_scancode", scancode, 0);
    chk("mid_rst_key_down", key_down, 0);
    chk("mid_rst_ext", ext, 0);
    chk("mid_rst_press_cnt", press_cnt, 0);
    chk("mid_rst_ovf_seen", ovf_seen, 0);
    chk("mid_rst_evt_valid", evt_valid, 0);
    fifo.delete();
    exp_q.delete();
    model_reset();
    kb_ready = 1'b0;
    repeat (2) tick();
    clrn = 1'b1;
    repeat (2) tick();
    send(8'h1C);
    drain();
    chk("post_rst_press_cnt", press_cnt, 8'h01);

    chk("events_outstanding", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
